// File: rtl/tug_referee_if.sv
// tug_referee_if: player, end-light and score/display signals of the tug-of-war referee
//   SCORE_W      width of each score counter
//   master       light row / player side: drives L, R, leftEndOn, rightEndOn
//   slave        referee side: drives restartGame, scores, matchOver, winnerLeft, hex displays
interface tug_referee_if #(parameter int SCORE_W = 3);
   logic               L, R, leftEndOn, rightEndOn;
   logic               restartGame, matchOver, winnerLeft;
   logic [SCORE_W-1:0] leftScore, rightScore;
   logic [6:0]         leftHex, rightHex;
   modport master (output L, R, leftEndOn, rightEndOn,
                   input restartGame, leftScore, rightScore, matchOver, winnerLeft, leftHex, rightHex);
   modport slave  (input L, R, leftEndOn, rightEndOn,
                   output restartGame, leftScore, rightScore, matchOver, winnerLeft, leftHex, rightHex);
endinterface

// File: rtl/tug_referee.sv
// tug_referee: awards points when a player pulls the light off their end, re-centers the row, ends the match
//   Clock        system clock, all state changes on posedge
//   Reset        asynchronous active-low reset
//   bus          tug_referee_if.slave: L/R presses, end lights in; restartGame, scores, matchOver,
//                winnerLeft, leftHex/rightHex out
//   TUG_REFEREE_HEX_EN  when defined, leftHex/rightHex decode the scores (active-low gfedcba);
//                       otherwise both are tied dark
module tug_referee #(
   parameter int SCORE_W     = 3,
   parameter int WIN_SCORE   = 7,
   parameter int HOLD_CYCLES = 4
) (
   input logic          Clock,
   input logic          Reset,
   tug_referee_if.slave bus
);
   localparam int CNT_W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] TOP = '1;
   typedef enum logic [1:0] {PLAY, POINT, DONE} state_t;
   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [SCORE_W-1:0] left_score, right_score;
   logic               restart, match_over, winner_left;
   logic               left_pt, right_pt;
   // both end lights lit at once is an illegal row state and never scores
   assign left_pt  = bus.leftEndOn & ~bus.rightEndOn & bus.L & ~bus.R;
   assign right_pt = bus.rightEndOn & ~bus.leftEndOn & bus.R & ~bus.L;
   function automatic logic [SCORE_W-1:0] inc(input logic [SCORE_W-1:0] s);
      return (s == TOP) ? s : s + 1'b1;
   endfunction
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state       <= PLAY;
         cnt         <= '0;
         left_score  <= '0;
         right_score <= '0;
         restart     <= 1'b0;
         match_over  <= 1'b0;
         winner_left <= 1'b0;
      end else begin
         case (state)
            PLAY: if (left_pt || right_pt) begin
               if (left_pt) left_score <= inc(left_score);
               if (right_pt) right_score <= inc(right_score);
               state   <= POINT;
               restart <= 1'b1;
               cnt     <= CNT_W'(HOLD_CYCLES - 1);
            end
            POINT: if (cnt == '0) begin
               restart <= 1'b0;
               if (left_score == WIN || right_score == WIN) begin
                  state       <= DONE;
                  match_over  <= 1'b1;
                  winner_left <= (left_score == WIN);
               end else begin
                  state <= PLAY;
               end
            end else begin
               cnt <= cnt - 1'b1;
            end
            DONE: restart <= 1'b0;
            default: state <= PLAY;
         endcase
      end
   end
   assign bus.restartGame = restart;
   assign bus.leftScore   = left_score;
   assign bus.rightScore  = right_score;
   assign bus.matchOver   = match_over;
   assign bus.winnerLeft  = winner_left;
`ifdef TUG_REFEREE_HEX_EN
   function automatic logic [6:0] hex7(input logic [SCORE_W-1:0] s);
      case (32'(s))
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction
   assign bus.leftHex  = hex7(left_score);
   assign bus.rightHex = hex7(right_score);
`else
   assign bus.leftHex  = 7'b1111111;
   assign bus.rightHex = 7'b1111111;
`endif
endmodule
